// File: rtl/carrier_nco_pkg.sv
// carrier_nco_pkg: shared constants, address map and register layout for the carrier NCO.
// NCOSPACE selects the NCO window on addr[11:4]; registers sit at addr[3:2].
package carrier_nco_pkg;

    localparam int unsigned NCO_PHASE_BITS    = 12;
    localparam int unsigned NCO_ROM_ADDR_BITS = 10;
    localparam int unsigned NCO_OUT_BITS      = 18;
    localparam int unsigned NCO_ROM_DATA_BITS = NCO_OUT_BITS - 1;
    localparam int unsigned NCO_ACC_BITS      = 32;
    localparam int unsigned BUS_ADDR_BITS     = 12;
    localparam int unsigned BUS_DATA_BITS     = 32;

    // addressMap: NCO register window
    localparam logic [7:0] NCOSPACE = 8'h10;

    typedef enum logic [1:0] {
        REG_CENTER = 2'd0,
        REG_CTRL   = 2'd1,
        REG_PHASE  = 2'd2,
        REG_FREQ   = 2'd3
    } nco_reg_e;

    // ctrl register, bit3..bit0
    typedef struct packed {
        logic hold_on_unlock;
        logic invert_spectrum;
        logic reset_phase;
        logic hold_offset;
    } nco_ctrl_t;

endpackage

// File: rtl/carrier_nco_if.sv
// carrier_nco_if: wr0..wr3/addr/din/dout microprocessor bus.
//   wr0..wr3 : byte-lane write strobes for din[7:0] .. din[31:24]
//   addr     : register address
//   din/dout : write data / combinational read data
interface carrier_nco_if;
    import carrier_nco_pkg::*;

    logic                     wr0;
    logic                     wr1;
    logic                     wr2;
    logic                     wr3;
    logic [BUS_ADDR_BITS-1:0] addr;
    logic [BUS_DATA_BITS-1:0] din;
    logic [BUS_DATA_BITS-1:0] dout;

    modport master (output wr0, wr1, wr2, wr3, addr, din, input dout);
    modport slave  (input wr0, wr1, wr2, wr3, addr, din, output dout);

endinterface

// File: rtl/carrier_nco_sin_rom.sv
// nco_sin_rom: 1024x17 quarter-wave sine table, synchronous, two read ports.
//   clk                    : clock
//   addr_sin_i, addr_cos_i : table addresses
//   data_sin_o, data_cos_o : T(addr), one cycle later
// T(a) = round(131071*sin(pi/2*(a+0.5)/1024)), evaluated at elaboration.
module nco_sin_rom
    import carrier_nco_pkg::*;
(
    input  logic                         clk,
    input  logic [NCO_ROM_ADDR_BITS-1:0] addr_sin_i,
    input  logic [NCO_ROM_ADDR_BITS-1:0] addr_cos_i,
    output logic [NCO_ROM_DATA_BITS-1:0] data_sin_o,
    output logic [NCO_ROM_DATA_BITS-1:0] data_cos_o
);

    localparam int unsigned DEPTH = 1 << NCO_ROM_ADDR_BITS;
    localparam logic [63:0] PI_Q48 = 64'h0003_243F_6A88_85A3;

    // Taylor series of sin in Q48 fixed point; 128-bit intermediates avoid overflow.
    function automatic logic [NCO_ROM_DATA_BITS-1:0] sin_entry(input int unsigned a);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        logic [127:0] scaled;
        x    = (128'(PI_Q48) * 128'(2 * a + 1)) >> 12;
        x2   = (x * x) >> 48;
        term = x;
        sum  = x;
        for (int k = 1; k <= 9; k++) begin
            term = ((term * x2) >> 48) / 128'((2 * k) * (2 * k + 1));
            if ((k % 2) == 1) sum = sum - term;
            else              sum = sum + term;
        end
        scaled = (sum * 128'(131071) + (128'(1) << 47)) >> 48;
        return NCO_ROM_DATA_BITS'(scaled);
    endfunction

    logic [NCO_ROM_DATA_BITS-1:0] table_c [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_tab
        localparam logic [NCO_ROM_DATA_BITS-1:0] ENTRY = sin_entry(i);
        assign table_c[i] = ENTRY;
    end

    always_ff @(posedge clk) begin
        data_sin_o <= table_c[addr_sin_i];
        data_cos_o <= table_c[addr_cos_i];
    end

endmodule

// File: rtl/carrier_nco.sv
// carrier_nco: carrier NCO with shadowed register bank and 4-stage quadrature output pipeline.
//   clk, reset        : clock, synchronous active-high reset
//   bus               : wr0..wr3/addr/din/dout register bus (NCOSPACE window)
//   ddcSync           : sample strobe; transfers shadows and advances the accumulator
//   carrierFreqOffset : loop offset, qualified by carrierFreqEn; carrierLock gates holdOnUnlock
//   sinOut, cosOut    : 18-bit two's-complement quadrature outputs
//   ncoValid          : pulse with each ddcSync-tagged sample, 4 clk after the strobe
//   freqWord          : active frequency word
// Optional: define NCO_DITHER_EN for LFSR phase dither.
module carrier_nco
    import carrier_nco_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    carrier_nco_if.slave            bus,
    input  logic                    ddcSync,
    input  logic [31:0]             carrierFreqOffset,
    input  logic                    carrierFreqEn,
    input  logic                    carrierLock,
    output logic [NCO_OUT_BITS-1:0] sinOut,
    output logic [NCO_OUT_BITS-1:0] cosOut,
    output logic                    ncoValid,
    output logic [31:0]             freqWord
);

    logic [31:0] center_sh_q, center_sh_d, center_q;
    logic [15:0] phase_sh_q, phase_sh_d, phase_off_q;
    nco_ctrl_t   ctrl_sh_q, ctrl_sh_d;
    logic        hold_offset_q, invert_q, hold_unlock_q;
    logic [31:0] offset_q, freq_word_q, freq_sum_c;
    logic [NCO_ACC_BITS-1:0]      acc_q;
    logic [NCO_PHASE_BITS-1:0]    acc_phase_c, p_q;
    logic [NCO_ROM_ADDR_BITS-1:0] sin_addr_c, cos_addr_c;
    logic [NCO_ROM_DATA_BITS-1:0] sin_t, cos_t;
    logic        v1_q, v2_q, v3_q, v4_q;
    logic        sin_neg_q, cos_neg_q;
    logic [NCO_OUT_BITS-1:0] sin_q, cos_q;
    logic        sel_c, latch_en_c;
    nco_reg_e    reg_c;
    logic [3:0]  lane_c;

    assign sel_c  = (bus.addr[11:4] == NCOSPACE);
    assign reg_c  = nco_reg_e'(bus.addr[3:2]);
    assign lane_c = {bus.wr3, bus.wr2, bus.wr1, bus.wr0};

    // Byte-lane merge of bus writes into the shadow registers
    always_comb begin
        center_sh_d = center_sh_q;
        phase_sh_d  = phase_sh_q;
        ctrl_sh_d   = ctrl_sh_q;
        if (sel_c) begin
            case (reg_c)
                REG_CENTER: for (int i = 0; i < 4; i++)
                                if (lane_c[i]) center_sh_d[8*i +: 8] = bus.din[8*i +: 8];
                REG_CTRL:   if (lane_c[0]) ctrl_sh_d = nco_ctrl_t'(bus.din[3:0]);
                REG_PHASE:  for (int i = 0; i < 2; i++)
                                if (lane_c[i]) phase_sh_d[8*i +: 8] = bus.din[8*i +: 8];
                default:    ;
            endcase
        end
    end

    // Readback of the active values; resetPhase always reads 0
    always_comb begin
        bus.dout = '0;
        if (sel_c) begin
            case (reg_c)
                REG_CENTER: bus.dout = center_q;
                REG_CTRL:   bus.dout = {28'h0, hold_unlock_q, invert_q, 1'b0, hold_offset_q};
                REG_PHASE:  bus.dout = {16'h0, phase_off_q};
                default:    bus.dout = freq_word_q;
            endcase
        end
    end

    assign latch_en_c = carrierFreqEn && !hold_offset_q && !(hold_unlock_q && !carrierLock);
    assign freq_sum_c = center_q + offset_q;

`ifdef NCO_DITHER_EN
    logic [14:0] lfsr_q;
    logic [19:0] dith_sum_c;
    // Dither enters at acc[19:12]; its carry reaches the phase index bits
    assign dith_sum_c  = acc_q[31:12] + 20'(lfsr_q[7:0]);
    assign acc_phase_c = dith_sum_c[19:8];

    always_ff @(posedge clk) begin
        if (reset)        lfsr_q <= 15'h0001;
        else if (ddcSync) lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    end
`else
    assign acc_phase_c = acc_q[31:20];
`endif

    // Quadrant mirror: odd quadrants read the table backwards; cos is quadrant+1
    assign sin_addr_c = p_q[10] ? ~p_q[9:0] :  p_q[9:0];
    assign cos_addr_c = p_q[10] ?  p_q[9:0] : ~p_q[9:0];

    nco_sin_rom u_rom (
        .clk        (clk),
        .addr_sin_i (sin_addr_c),
        .addr_cos_i (cos_addr_c),
        .data_sin_o (sin_t),
        .data_cos_o (cos_t)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            center_sh_q   <= '0;
            phase_sh_q    <= '0;
            ctrl_sh_q     <= '0;
            center_q      <= '0;
            phase_off_q   <= '0;
            hold_offset_q <= 1'b0;
            invert_q      <= 1'b0;
            hold_unlock_q <= 1'b0;
            offset_q      <= '0;
            freq_word_q   <= '0;
            acc_q         <= '0;
            p_q           <= '0;
            v1_q          <= 1'b0;
            v2_q          <= 1'b0;
            v3_q          <= 1'b0;
            v4_q          <= 1'b0;
            sin_neg_q     <= 1'b0;
            cos_neg_q     <= 1'b0;
            sin_q         <= '0;
            cos_q         <= '0;
        end else begin
            center_sh_q <= center_sh_d;
            phase_sh_q  <= phase_sh_d;
            ctrl_sh_q   <= ctrl_sh_d;
            if (ddcSync) begin
                ctrl_sh_q.reset_phase <= 1'b0;
                center_q      <= center_sh_d;
                phase_off_q   <= phase_sh_d;
                hold_offset_q <= ctrl_sh_d.hold_offset;
                invert_q      <= ctrl_sh_d.invert_spectrum;
                hold_unlock_q <= ctrl_sh_d.hold_on_unlock;
                acc_q         <= ctrl_sh_d.reset_phase ? '0 : acc_q + freq_word_q;
            end
            if (latch_en_c) offset_q <= carrierFreqOffset;
            freq_word_q <= invert_q ? (32'd0 - freq_sum_c) : freq_sum_c;
            // Pipeline free-runs; the valid tag marks strobe samples
            v1_q      <= ddcSync;
            p_q       <= acc_phase_c + phase_off_q[15:4];
            v2_q      <= v1_q;
            sin_neg_q <= p_q[11];
            cos_neg_q <= p_q[11] ^ p_q[10];
            v3_q      <= v2_q;
            sin_q     <= sin_neg_q ? (18'd0 - {1'b0, sin_t}) : {1'b0, sin_t};
            cos_q     <= cos_neg_q ? (18'd0 - {1'b0, cos_t}) : {1'b0, cos_t};
            v4_q      <= v3_q;
        end
    end

    assign sinOut   = sin_q;
    assign cosOut   = cos_q;
    assign ncoValid = v4_q;
    assign freqWord = freq_word_q;

endmodule

// File: tb/tb_carrier_nco.sv
// tb_carrier_nco: directed, table-driven bench for carrier_nco.
module tb_carrier_nco;
    import carrier_nco_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        sync_r;
    logic [31:0] offset_r;
    logic        en_r;
    logic        lock_r;
    logic [17:0] sin_w, cos_w;
    logic        valid_w;
    logic [31:0] freq_w;

    int checks = 0;
    int errors = 0;

    carrier_nco_if bus ();

    carrier_nco dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .ddcSync           (sync_r),
        .carrierFreqOffset (offset_r),
        .carrierFreqEn     (en_r),
        .carrierLock       (lock_r),
        .sinOut            (sin_w),
        .cosOut            (cos_w),
        .ncoValid          (valid_w),
        .freqWord          (freq_w)
    );

    always #5 clk = ~clk;

    localparam logic [17:0] P101 = 18'd101;
    localparam logic [17:0] PMAX = 18'd131071;
    localparam logic [17:0] N101 = 18'h3FF9B;   // -101
    localparam logic [17:0] NMAX = 18'h20001;   // -131071

    typedef struct {
        logic [31:0] center;
        logic [15:0] phase;
        logic [3:0]  ctrl;
        logic [31:0] exp_freq;
        logic [17:0] exp_sin;
        logic [17:0] exp_cos;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus write cycle, optionally with ddcSync in the same cycle
    task automatic bus_write(input logic [1:0] off, input logic [31:0] data,
                             input logic [3:0] lanes, input logic with_sync);
        bus.addr = {NCOSPACE, off, 2'b00};
        bus.din  = data;
        {bus.wr3, bus.wr2, bus.wr1, bus.wr0} = lanes;
        sync_r = with_sync;
        step();
        {bus.wr3, bus.wr2, bus.wr1, bus.wr0} = 4'h0;
        sync_r = 1'b0;
    endtask

    task automatic bus_read_check(input string name, input logic [1:0] off, input logic [31:0] exp);
        bus.addr = {NCOSPACE, off, 2'b00};
        #1;
        check(name, bus.dout, exp);
    endtask

    task automatic pulse_en(input logic [31:0] off);
        offset_r = off;
        en_r     = 1'b1;
        step();
        en_r     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sync_r = 1'b0; offset_r = '0; en_r = 1'b0; lock_r = 1'b1;
        bus.addr = '0; bus.din = '0;
        {bus.wr3, bus.wr2, bus.wr1, bus.wr0} = 4'h0;

        vecs[0] = '{32'h4000_0000, 16'h0000, 4'h2, 32'h4000_0000, P101, PMAX};
        vecs[1] = '{32'h4000_0000, 16'h0000, 4'h0, 32'h4000_0000, PMAX, N101};
        vecs[2] = '{32'h4000_0000, 16'h0000, 4'h0, 32'h4000_0000, N101, NMAX};
        vecs[3] = '{32'h4000_0000, 16'h0000, 4'h0, 32'h4000_0000, NMAX, P101};
        vecs[4] = '{32'h4000_0000, 16'h0000, 4'h6, 32'hC000_0000, P101, PMAX};
        vecs[5] = '{32'h4000_0000, 16'h0000, 4'h4, 32'hC000_0000, NMAX, P101};
        vecs[6] = '{32'h4000_0000, 16'h0000, 4'h4, 32'hC000_0000, N101, NMAX};
        vecs[7] = '{32'h4000_0000, 16'h0000, 4'h4, 32'hC000_0000, PMAX, N101};
        vecs[8] = '{32'h0000_0000, 16'h4000, 4'h2, 32'h0000_0000, PMAX, N101};

        // Reset values
        repeat (3) step();
        reset = 1'b0;
        check("rst sin",   {14'h0, sin_w}, 32'h0);
        check("rst cos",   {14'h0, cos_w}, 32'h0);
        check("rst valid", {31'h0, valid_w}, 32'h0);
        check("rst freq",  freq_w, 32'h0);
        bus_read_check("rst center rd", REG_CENTER, 32'h0);
        bus_read_check("rst ctrl rd",   REG_CTRL,   32'h0);

        // Shadow write is invisible until a ddcSync transfers it
        bus_write(REG_CENTER, 32'h1234_5678, 4'hF, 1'b0);
        step(); step();
        bus_read_check("shadow center rd", REG_CENTER, 32'h0);
        check("shadow freq", freq_w, 32'h0);
        sync_r = 1'b1; step(); sync_r = 1'b0;
        bus_read_check("xfer center rd", REG_CENTER, 32'h1234_5678);
        bus_write(REG_CENTER, 32'hAABB_CCDD, 4'b0101, 1'b1);
        bus_read_check("lane center rd", REG_CENTER, 32'h12BB_56DD);
        step();
        bus_read_check("freq rd", REG_FREQ, 32'h12BB_56DD);
        bus.addr = 12'h200;
        #1;
        check("out-of-window rd", bus.dout, 32'h0);

        // Table: one tagged sample per record
        for (int i = 0; i < 9; i++) begin
            bus_write(REG_CENTER, vecs[i].center, 4'hF, 1'b0);
            bus_write(REG_PHASE, {16'h0, vecs[i].phase}, 4'hF, 1'b0);
            bus_write(REG_CTRL, {28'h0, vecs[i].ctrl}, 4'h1, 1'b1);
            for (int k = 1; k <= 4; k++) begin
                check($sformatf("vec%0d valid@%0d", i, k), {31'h0, valid_w}, {31'h0, (k == 4)});
                if (k < 4) step();
            end
            check($sformatf("vec%0d sin", i),  {14'h0, sin_w}, {14'h0, vecs[i].exp_sin});
            check($sformatf("vec%0d cos", i),  {14'h0, cos_w}, {14'h0, vecs[i].exp_cos});
            check($sformatf("vec%0d freq", i), freq_w, vecs[i].exp_freq);
            step();
            check($sformatf("vec%0d valid end", i), {31'h0, valid_w}, 32'h0);
        end

        // Offset path latency and back-to-back strobes
        bus_write(REG_PHASE, 32'h0, 4'hF, 1'b0);
        bus_write(REG_CTRL, 32'h2, 4'h1, 1'b1);
        pulse_en(32'h0010_0000);
        check("offs freq m+1", freq_w, 32'h0);
        sync_r = 1'b1;
        step();
        check("offs freq m+2", freq_w, 32'h0010_0000);
        step(); step();
        sync_r = 1'b0;
        step();
        check("b2b valid0", {31'h0, valid_w}, 32'h1);
        check("b2b sin0", {14'h0, sin_w}, 32'd101);
        step();
        check("b2b valid1", {31'h0, valid_w}, 32'h1);
        check("b2b sin1", {14'h0, sin_w}, 32'd302);
        step();
        check("b2b valid2", {31'h0, valid_w}, 32'h1);
        check("b2b sin2", {14'h0, sin_w}, 32'd503);
        step();
        check("b2b valid end", {31'h0, valid_w}, 32'h0);

        // holdOnUnlock, then holdOffset
        bus_write(REG_CTRL, 32'h8, 4'h1, 1'b1);
        lock_r = 1'b0;
        pulse_en(32'h0020_0000);
        step(); step();
        check("unlock hold freq", freq_w, 32'h0010_0000);
        lock_r = 1'b1;
        pulse_en(32'h0030_0000);
        step();
        check("relock freq", freq_w, 32'h0030_0000);
        bus_write(REG_CTRL, 32'h3, 4'h1, 1'b1);
        bus_read_check("ctrl rd selfclear", REG_CTRL, 32'h1);
        pulse_en(32'h0040_0000);
        step(); step();
        check("hold offset freq", freq_w, 32'h0030_0000);
        bus_write(REG_CTRL, 32'h0, 4'h1, 1'b1);

        // Reset during a running pipeline
        sync_r = 1'b1;
        step(); step(); step();
        sync_r = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst sin",   {14'h0, sin_w}, 32'h0);
        check("midrst cos",   {14'h0, cos_w}, 32'h0);
        check("midrst valid", {31'h0, valid_w}, 32'h0);
        check("midrst freq",  freq_w, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("midrst no valid %0d", k), {31'h0, valid_w}, 32'h0);
        end

        // resetPhase returns the accumulator to 0
        bus_write(REG_CENTER, 32'h4000_0000, 4'hF, 1'b1);
        step(); step();
        sync_r = 1'b1; step(); sync_r = 1'b0;
        step(); step(); step();
        check("pre-rp valid", {31'h0, valid_w}, 32'h1);
        check("pre-rp sin", {14'h0, sin_w}, {14'h0, PMAX});
        step();
        bus_write(REG_CTRL, 32'h2, 4'h1, 1'b1);
        step(); step(); step();
        check("rp valid", {31'h0, valid_w}, 32'h1);
        check("rp sin", {14'h0, sin_w}, {14'h0, P101});
        check("rp cos", {14'h0, cos_w}, {14'h0, PMAX});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
